pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter: DATA_W, default 8, payload width in bits (legal 1..64).
REQ-002 Parameter: RESET_DATA, default 0, value loaded into every data register on reset and flush.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  upstream beat present.
REQ-006 Port: in_ready  output  1  stage accepts beat this cycle.
REQ-007 Port: in_data  input  DATA_W  upstream payload.
REQ-008 Port: out_valid  output  1  beat presented downstream.
REQ-009 Port: out_ready  input  1  downstream accepts beat.
REQ-010 Port: out_data  output  DATA_W  downstream payload, driven directly from the head register.
REQ-011 Port: stall  input  1  hazard freeze; holds all stage contents.
REQ-012 Port: flush  input  1  discard all held beats (branch/mispredict kill).
REQ-013 Port: occupancy  output  2  number of beats held (0..2).
REQ-014 Port: drop_cnt  output  8  saturating count of flushes that discarded at least one beat.

Function
REQ-015 Accept = in_valid & in_ready; pop = out_valid & out_ready; both SHALL be evaluated in the same cycle.
REQ-016 With stall=1: in_ready=0, out_valid=0, and contents, state and occupancy SHALL be unchanged.
REQ-017 out_valid SHALL be 1 iff occupancy>0 and stall=0.
REQ-018 Beats SHALL leave in acceptance order, with no duplication and no loss except on flush.
REQ-019 Latency: a beat accepted into an empty stage SHALL appear on out_valid/out_data in the next cycle.
REQ-020 flush SHALL have priority over stall, accept and pop: next state EMPTY, occupancy 0, data registers set to RESET_DATA, and any beat offered that cycle SHALL be dropped.
REQ-021 drop_cnt SHALL increment by 1 on each flush cycle with occupancy>0, SHALL saturate at 255, and SHALL NOT clear on flush.
REQ-022 Skid mode states: EMPTY (occ 0), BUSY (occ 1, head only), FULL (occ 2, head plus skid).
REQ-023 EMPTY: accept -> BUSY, head<=in_data.
REQ-024 BUSY: accept and no pop -> FULL, skid<=in_data; accept and pop -> BUSY, head<=in_data; pop only -> EMPTY.
REQ-025 FULL: pop -> BUSY, head<=skid; no pop -> FULL, hold.
REQ-026 Skid mode: in_ready = (state!=FULL) & ~stall; in_ready SHALL NOT depend combinationally on out_ready.
REQ-027 Skid mode SHALL sustain 1 beat/cycle under continuous in_valid and out_ready.

Reset
REQ-028 While reset_n=0, independent of clk: state EMPTY, occupancy 0, out_valid 0, in_ready 0, head and skid = RESET_DATA, drop_cnt 0.
REQ-029 in_ready SHALL be 1 (when stall=0) from the first rising edge after reset_n deasserts.
REQ-030 Reset asserted mid-transfer SHALL discard all held beats and SHALL NOT increment drop_cnt.

Configuration
REQ-031 Macro PIPE_STAGE_SKID_EN defined: two-entry skid behaviour per REQ-022..REQ-027.
REQ-032 PIPE_STAGE_SKID_EN undefined: single head register only; occupancy 0..1; in_ready = ~stall & (occupancy==0 | out_ready), combinational through out_ready; accept and pop in the same cycle SHALL reload head; all other REQs apply unchanged.

Verification
REQ-033 Reset: reset_n=0 for 2 cycles, then release -> occupancy 0, out_valid 0, drop_cnt 0, and in_ready 1 after the first edge.
REQ-034 Streaming: in_data 0x01..0x10 with out_ready=1 -> 0x01..0x10 output in order, one per cycle, 1-cycle latency, no bubbles (both configs).
REQ-035 Backpressure (skid): push 0xA5 and 0x5A with out_ready=0 -> occupancy 2 and in_ready 0; raise out_ready -> 0xA5 then 0x5A output, then occupancy 0.
REQ-036 Stall: occupancy 1 holding 0x3C, stall=1 for 3 cycles with in_valid=1 -> out_valid 0, in_ready 0, and no change; on release, 0x3C emitted once.
REQ-037 Flush: occupancy 2, flush=1 with in_valid=1 and in_data=0x77 -> next cycle occupancy 0, drop_cnt 1, and 0x77 never emitted; 300 such flushes -> drop_cnt 255.
REQ-038 Async reset: assert reset_n=0 between clock edges while FULL -> out_valid 0 immediately and occupancy 0, with drop_cnt unchanged from 0.

Source files
------------

// File: rtl/pipe_stage.sv
// pipe_stage: single valid/ready pipeline stage with stall, flush and a saturating drop counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer; by default only a head register exists.
module pipe_stage #(
   parameter int unsigned       DATA_W     = 8,
   parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              stall,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [7:0]        drop_cnt,
   output logic [1:0]        state_dbg
);

   // Handshake: a beat moves on a rising edge where valid and ready are both high;
   // valid never waits for ready, and a flush in the same cycle discards it instead.

   // Encoding equals the number of held beats, so occupancy is the state itself.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
`ifdef PIPE_STAGE_SKID_EN
   localparam logic [1:0] ST_FULL  = 2'd2;
`endif

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [7:0]        drop_q, drop_d;
   logic              live_q;
   logic              accept, pop;
`ifdef PIPE_STAGE_SKID_EN
   logic [DATA_W-1:0] skid_q, skid_d;
`endif

   assign out_valid = (state_q != ST_EMPTY) & ~stall;
`ifdef PIPE_STAGE_SKID_EN
   assign in_ready  = live_q & ~stall & (state_q != ST_FULL);
`else
   // Without a skid slot, a busy head can only take a new beat while it is leaving.
   assign in_ready  = live_q & ~stall & ((state_q == ST_EMPTY) | out_ready);
`endif

   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = head_q;
   assign occupancy = state_q;
   assign drop_cnt  = drop_q;
   assign state_dbg = state_q;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      drop_d  = drop_q;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = skid_q;
`endif
      if (flush) begin
         state_d = ST_EMPTY;
         head_d  = RESET_DATA;
`ifdef PIPE_STAGE_SKID_EN
         skid_d  = RESET_DATA;
`endif
         if ((state_q != ST_EMPTY) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
         end
      end else if (!stall) begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_BUSY;
                  head_d  = in_data;
               end
            end
            ST_BUSY: begin
`ifdef PIPE_STAGE_SKID_EN
               if (accept && !pop) begin
                  state_d = ST_FULL;
                  skid_d  = in_data;
               end else if (accept && pop) begin
                  head_d  = in_data;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
`else
               if (accept) begin
                  head_d  = in_data;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
`endif
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_FULL: begin
               if (pop) begin
                  state_d = ST_BUSY;
                  head_d  = skid_q;
               end
            end
`endif
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_EMPTY;
         head_q  <= RESET_DATA;
         drop_q  <= 8'd0;
         live_q  <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
         skid_q  <= RESET_DATA;
`endif
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         drop_q  <= drop_d;
         live_q  <= 1'b1;
`ifdef PIPE_STAGE_SKID_EN
         skid_q  <= skid_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipe_stage.sv
// Testbench for pipe_stage: directed scenarios plus random traffic checked against a queue model.
module tb_pipe_stage;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       stall;
   logic       flush;
   logic [1:0] occupancy;
   logic [7:0] drop_cnt;
   logic [1:0] state_dbg;

`ifdef PIPE_STAGE_SKID_EN
   localparam int CAPACITY = 2;
`else
   localparam int CAPACITY = 1;
`endif

   int errors = 0;
   int checks = 0;

   logic [7:0] m_q[$];
   logic       m_live;
   int         m_drops;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   pipe_stage #(.DATA_W(8), .RESET_DATA(8'h00)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .stall     (stall),
      .flush     (flush),
      .occupancy (occupancy),
      .drop_cnt  (drop_cnt),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic m_in_ready();
      if (!reset_n || !m_live || stall) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      return m_q.size() < 2;
`else
      return (m_q.size() == 0) || out_ready;
`endif
   endfunction

   function automatic logic m_out_valid();
      return reset_n && (m_q.size() > 0) && !stall;
   endfunction

   task automatic drive(input logic v, input logic [7:0] d, input logic ordy,
                        input logic st, input logic fl);
      in_valid = v; in_data = d; out_ready = ordy; stall = st; flush = fl;
      #1;
   endtask

   // Samples both the model's and the DUT's transfers, then advances one clock.
   task automatic tick();
      logic acc, pp, fl;
      logic [7:0] d;
      acc = in_valid && m_in_ready();
      pp  = m_out_valid() && out_ready;
      fl  = flush;
      d   = in_data;
      if (reset_n && out_valid && out_ready && !flush) got_q.push_back(out_data);
      @(posedge clk);
      if (!reset_n) begin
         m_q.delete(); m_drops = 0; m_live = 1'b0;
      end else begin
         if (fl) begin
            if (m_q.size() > 0 && m_drops < 255) m_drops++;
            m_q.delete();
         end else begin
            if (pp) exp_q.push_back(m_q.pop_front());
            if (acc) m_q.push_back(d);
         end
         m_live = 1'b1;
      end
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      m_q.delete(); m_drops = 0; m_live = 1'b0;
      drive(0, 8'h00, 0, 0, 0);
      tick(); tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      m_q.delete(); m_drops = 0; m_live = 1'b0;
      drive(0, 8'h00, 0, 0, 0);
      tick(); tick();
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
      reset_n = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL post_reset_occ: got %0d want 0", occupancy); end
   endtask

   task automatic test_streaming();
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         drive(1, 8'(i + 1), 1, 0, 0);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
         if (i > 0) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
               errors++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 8'(i));
            end
         end
         tick();
      end
      drive(0, 8'h00, 1, 0, 0);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin
         errors++; $display("FAIL stream_last: got v=%b d=%h want v=1 d=10", out_valid, out_data);
      end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", out_valid); end
      checks++; if (got_q.size() != 16) begin errors++; $display("FAIL stream_count: got %0d want 16", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 16; i++) begin
         checks++; if (got_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL stream_order[%0d]: got %h want %h", i, got_q[i], 8'(i + 1)); end
      end
   endtask

   task automatic test_backpressure();
      got_q.delete(); exp_q.delete();
      drive(1, 8'hA5, 0, 0, 0); tick();
      drive(1, 8'h5A, 0, 0, 0); tick();
      drive(0, 8'h00, 0, 0, 0);
      checks++; if (occupancy !== 2'(CAPACITY)) begin errors++; $display("FAIL bp_occ: got %0d want %0d", occupancy, CAPACITY); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      drive(0, 8'h00, 1, 0, 0);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL bp_first: got v=%b d=%h want v=1 d=a5", out_valid, out_data); end
      tick();
`ifdef PIPE_STAGE_SKID_EN
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin errors++; $display("FAIL bp_second: got v=%b d=%h want v=1 d=5a", out_valid, out_data); end
      tick();
`endif
      checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid); end
      checks++; if (got_q.size() != CAPACITY || got_q[0] !== 8'hA5) begin errors++; $display("FAIL bp_seq: got n=%0d want n=%0d first a5", got_q.size(), CAPACITY); end
   endtask

   task automatic test_stall();
      got_q.delete(); exp_q.delete();
      drive(1, 8'h3C, 0, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 8'h99, 1, 1, 0);
         checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_hs[%0d]: got v=%b r=%b want 0 0", i, out_valid, in_ready); end
         checks++; if (occupancy !== 2'd1 || out_data !== 8'h3C) begin errors++; $display("FAIL stall_hold[%0d]: got occ=%0d d=%h want 1 3c", i, occupancy, out_data); end
         tick();
      end
      drive(0, 8'h00, 1, 0, 0);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin errors++; $display("FAIL stall_release: got v=%b d=%h want 1 3c", out_valid, out_data); end
      tick();
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stall_after: got v=%b occ=%0d want 0 0", out_valid, occupancy); end
      checks++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin errors++; $display("FAIL stall_once: got n=%0d want 1 beat of 3c", got_q.size()); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < CAPACITY; i++) begin
         drive(1, 8'(8'h11 * (i + 1)), 0, 0, 0); tick();
      end
      drive(0, 8'h00, 0, 0, 0);
      checks++; if (occupancy !== 2'(CAPACITY)) begin errors++; $display("FAIL areset_fill: got %0d want %0d", occupancy, CAPACITY); end
      #2;
      reset_n = 1'b0;
      m_q.delete(); m_drops = 0; m_live = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL areset_now: got v=%b occ=%0d want 0 0", out_valid, occupancy); end
      checks++; if (drop_cnt !== 8'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL areset_cnt: got drop=%0d r=%b want 0 0", drop_cnt, in_ready); end
      tick();
      reset_n = 1'b1;
      tick();
      checks++; if (drop_cnt !== 8'd0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
         errors++; $display("FAIL areset_release: got drop=%0d r=%b occ=%0d want 0 1 0", drop_cnt, in_ready, occupancy);
      end
   endtask

   task automatic test_random();
      logic v, ordy, st, fl;
      logic [7:0] d;
      apply_reset();
      got_q.delete(); exp_q.delete();
      for (int c = 0; c < 600; c++) begin
         v    = 1'($urandom_range(0, 1));
         d    = 8'($urandom_range(0, 255));
         ordy = ($urandom_range(0, 3) != 0);
         st   = ($urandom_range(0, 9) == 0);
         fl   = ($urandom_range(0, 24) == 0);
         drive(v, d, ordy, st, fl);
         checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_ready, m_in_ready()); end
         checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", c, out_valid, m_out_valid()); end
         checks++; if (occupancy !== 2'(m_q.size())) begin errors++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", c, occupancy, m_q.size()); end
         checks++; if (drop_cnt !== 8'(m_drops)) begin errors++; $display("FAIL rnd_drop[%0d]: got %0d want %0d", c, drop_cnt, m_drops); end
         if (m_q.size() > 0) begin
            checks++; if (out_data !== m_q[0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", c, out_data, m_q[0]); end
         end
         tick();
      end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_sb_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_sb[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_flush();
      logic seen77;
      apply_reset();
      got_q.delete(); exp_q.delete();
      drive(0, 8'h00, 0, 0, 1); tick();
      drive(0, 8'h00, 0, 0, 0);
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL flush_empty: got %0d want 0", drop_cnt); end
      for (int i = 0; i < CAPACITY; i++) begin
         drive(1, 8'(8'h40 + i), 0, 0, 0); tick();
      end
      drive(0, 8'h00, 0, 0, 0);
      checks++; if (occupancy !== 2'(CAPACITY)) begin errors++; $display("FAIL flush_fill: got %0d want %0d", occupancy, CAPACITY); end
      drive(1, 8'h77, 0, 0, 1); tick();
      drive(0, 8'h00, 1, 0, 0);
      checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got occ=%0d v=%b want 0 0", occupancy, out_valid); end
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL flush_drop1: got %0d want 1", drop_cnt); end
      for (int i = 0; i < 3; i++) tick();
      seen77 = 1'b0;
      foreach (got_q[i]) if (got_q[i] === 8'h77) seen77 = 1'b1;
      checks++; if (seen77 !== 1'b0 || got_q.size() != 0) begin errors++; $display("FAIL flush_leak: got n=%0d seen77=%b want 0 0", got_q.size(), seen77); end
      drive(1, 8'h55, 0, 0, 0); tick();
      drive(1, 8'h66, 0, 1, 1); tick();
      drive(0, 8'h00, 0, 0, 0);
      checks++; if (occupancy !== 2'd0 || drop_cnt !== 8'd2) begin errors++; $display("FAIL flush_stall: got occ=%0d drop=%0d want 0 2", occupancy, drop_cnt); end
      for (int i = 0; i < 300; i++) begin
         drive(1, 8'($urandom_range(0, 255)), 0, 0, 0); tick();
         drive(1, 8'h77, 0, 0, 1); tick();
         drive(0, 8'h00, 0, 0, 0);
         checks++; if (drop_cnt !== 8'(m_drops)) begin errors++; $display("FAIL flush_count[%0d]: got %0d want %0d", i, drop_cnt, m_drops); end
      end
      checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL flush_sat: got %0d want 255", drop_cnt); end
   endtask

   initial begin
      reset_n = 1'b0;
      m_live  = 1'b0;
      m_drops = 0;
      drive(0, 8'h00, 0, 0, 0);
      test_reset();
      test_streaming();
      test_backpressure();
      test_stall();
      test_async_reset();
      test_random();
      test_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
